// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a client and serial_adder
//
// Purpose: groups the start/operand request and the busy/done/result response
//          of one bit-serial adder into a single port.
// Signals:
//   start_in   client -> adder  request to sample operands and begin an addition
//   a_in       client -> adder  operand A (WIDTH bits)
//   b_in       client -> adder  operand B (WIDTH bits)
//   c_in       client -> adder  carry-in
//   busy_out   adder -> client  addition in progress
//   done_out   adder -> client  one-cycle pulse, result just updated
//   sum_out    adder -> client  sum of last completed addition (WIDTH bits)
//   carry_out  adder -> client  carry-out of last completed addition
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             c_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] sum_out;
    logic             carry_out;

    modport master (
        output start_in, a_in, b_in, c_in,
        input  busy_out, done_out, sum_out, carry_out
    );

    modport slave (
        input  start_in, a_in, b_in, c_in,
        output busy_out, done_out, sum_out, carry_out
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, one bit per clock, LSB first
//
// Purpose: adds two WIDTH-bit operands plus carry-in with a single full adder,
//          reusing it once per clock and keeping the carry in a flip-flop.
// Ports:
//   clk_in    clock, all state updates on the rising edge
//   rst_n_in  asynchronous active-low reset
//   bus       serial_adder_if.slave: start/operands in, busy/done/sum/carry out

module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);
    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (a_in & c_in) | (b_in & c_in);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    serial_adder_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_sum;
    logic fa_carry;
    logic load;
    logic last_bit;

    full_adder u_fa (
        .a_in      (a_q[0]),
        .b_in      (b_q[0]),
        .c_in      (carry_q),
        .sum_out   (fa_sum),
        .carry_out (fa_carry)
    );

    // A new request is only honoured outside SHIFT; start while busy is dropped.
    assign load     = bus.start_in && (state_q != S_SHIFT);
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_in) state_d = S_SHIFT;
            S_SHIFT: if (last_bit)     state_d = S_DONE;
            S_DONE:  state_d = bus.start_in ? S_SHIFT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so they are glitch-free.
    always_comb begin
        bus.busy_out  = (state_q == S_SHIFT);
        bus.done_out  = (state_q == S_DONE);
        bus.sum_out   = sum_q;
        bus.carry_out = cout_q;
    end

    // Datapath next-state
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (load) begin
            a_d     = bus.a_in;
            b_d     = bus.b_in;
            carry_d = bus.c_in;
            cnt_d   = '0;
        end else if (state_q == S_SHIFT) begin
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at LSB.
            acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
            carry_d = fa_carry;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
                sum_d  = {fa_sum, acc_q[WIDTH-1:1]};
                cout_d = fa_carry;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH 8 and 4)
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int n_assert;
    int n_fail;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(4)) bus4 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(4)) u_dut4 (.clk_in(clk), .rst_n_in(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One isolated addition on the 8-bit adder, starting from IDLE.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input string tag);
        logic [8:0] exp;
        logic [7:0] prev;
        int         k;
        bit         seen;
        bit         moved;
        exp  = 9'(a) + 9'(b) + 9'(c);
        prev = bus8.sum_out;
        bus8.start_in = 1'b1;
        bus8.a_in     = a;
        bus8.b_in     = b;
        bus8.c_in     = c;
        @(negedge clk);
        bus8.start_in = 1'b0;
        bus8.a_in     = 8'($urandom);
        bus8.b_in     = 8'($urandom);
        bus8.c_in     = 1'($urandom);
        seen  = 0;
        moved = 0;
        k     = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (bus8.done_out) seen = 1;
            else if (bus8.sum_out !== prev) moved = 1;
        end
        chk({tag, " latency"}, 64'(k), 64'(8));
        chk({tag, " held"}, 64'(moved), 64'(0));
        chk({tag, " sum"}, 64'(bus8.sum_out), 64'(exp[7:0]));
        chk({tag, " carry"}, 64'(bus8.carry_out), 64'(exp[8]));
        @(negedge clk);
        chk({tag, " pulse"}, 64'(bus8.done_out), 64'(0));
    endtask

    // Same for the 4-bit adder; only the result and hold checks matter here.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c);
        logic [4:0] exp;
        logic [3:0] prev;
        int         k;
        bit         seen;
        bit         moved;
        exp  = 5'(a) + 5'(b) + 5'(c);
        prev = bus4.sum_out;
        bus4.start_in = 1'b1;
        bus4.a_in     = a;
        bus4.b_in     = b;
        bus4.c_in     = c;
        @(negedge clk);
        bus4.start_in = 1'b0;
        seen  = 0;
        moved = 0;
        k     = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus4.done_out) seen = 1;
            else if (bus4.sum_out !== prev) moved = 1;
        end
        chk("w4 latency", 64'(k), 64'(4));
        chk("w4 held", 64'(moved), 64'(0));
        chk("w4 result", 64'({bus4.carry_out, bus4.sum_out}), 64'(exp));
        @(negedge clk);
    endtask

    initial begin
        logic [8:0] exp_q[$];
        logic [8:0] e;
        logic [7:0] a0, b0;
        logic       c0;
        int         dones, gap, busy_bad, results, k;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus8.start_in = 0; bus8.a_in = 0; bus8.b_in = 0; bus8.c_in = 0;
        bus4.start_in = 0; bus4.a_in = 0; bus4.b_in = 0; bus4.c_in = 0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(bus8.busy_out), 64'(0));
        chk("reset done", 64'(bus8.done_out), 64'(0));
        chk("reset sum", 64'(bus8.sum_out), 64'(0));
        chk("reset carry", 64'(bus8.carry_out), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed values
        op8(8'h3C, 8'h5A, 1'b0, "3c+5a");
        op8(8'hFF, 8'h01, 1'b0, "ff+01");
        op8(8'hFF, 8'hFF, 1'b1, "ff+ff+1");
        op8(8'h00, 8'h00, 1'b0, "zero");
        op8(8'h80, 8'h80, 1'b1, "msb");
        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), "random");

        // Reset in the middle of SHIFT clears everything at once.
        op8(8'h3C, 8'h5A, 1'b0, "pre-reset");
        bus8.start_in = 1'b1; bus8.a_in = 8'hFF; bus8.b_in = 8'h01; bus8.c_in = 1'b0;
        @(negedge clk);
        bus8.start_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid busy", 64'(bus8.busy_out), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async busy", 64'(bus8.busy_out), 64'(0));
        chk("async done", 64'(bus8.done_out), 64'(0));
        chk("async sum", 64'(bus8.sum_out), 64'(0));
        chk("async carry", 64'(bus8.carry_out), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus8.done_out) dones++;
        end
        chk("no done after reset", 64'(dones), 64'(0));

        // Start pulse and operand changes while busy are ignored.
        a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
        e  = 9'(a0) + 9'(b0) + 9'(c0);
        bus8.start_in = 1'b1; bus8.a_in = a0; bus8.b_in = b0; bus8.c_in = c0;
        @(negedge clk);
        bus8.start_in = 1'b0;
        repeat (3) @(negedge clk);
        bus8.start_in = 1'b1; bus8.a_in = ~a0; bus8.b_in = ~b0; bus8.c_in = ~c0;
        @(negedge clk);
        bus8.start_in = 1'b0;
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus8.done_out) begin
                dones++;
                chk("busy-ign result", 64'({bus8.carry_out, bus8.sum_out}), 64'(e));
            end
        end
        chk("busy-ign dones", 64'(dones), 64'(1));

        // start held high: one result every WIDTH+1 cycles.
        a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
        bus8.start_in = 1'b1; bus8.a_in = a0; bus8.b_in = b0; bus8.c_in = c0;
        exp_q.push_back(9'(a0) + 9'(b0) + 9'(c0));
        results = 0; gap = 0; busy_bad = 0; k = 0;
        while (results < 6 && k < 100) begin
            @(negedge clk);
            k++;
            gap++;
            if (bus8.done_out) begin
                results++;
                chk("stream period", 64'(gap), 64'(9));
                chk("stream busy", 64'(bus8.busy_out), 64'(0));
                e = exp_q.pop_front();
                chk("stream result", 64'({bus8.carry_out, bus8.sum_out}), 64'(e));
                gap = 0;
                if (results < 6) begin
                    a0 = 8'($urandom); b0 = 8'($urandom); c0 = 1'($urandom);
                    bus8.a_in = a0; bus8.b_in = b0; bus8.c_in = c0;
                    exp_q.push_back(9'(a0) + 9'(b0) + 9'(c0));
                end else begin
                    bus8.start_in = 1'b0;
                end
            end else if (!bus8.busy_out) begin
                busy_bad++;
            end
        end
        chk("stream count", 64'(results), 64'(6));
        chk("stream busy gaps", 64'(busy_bad), 64'(0));
        repeat (2) @(negedge clk);

        // Exhaustive 4-bit sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
